seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder_pkg.sv | 33 +++
 rtl/seg7_to_bcd.sv | 31 +++
 rtl/seg_scan_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_decoder_pkg : shared sampler states, COM codes, 7-seg patterns  (rev 1.0)
// ---------------------------------------------------------------------------
package seg_scan_decoder_pkg;

  typedef enum logic [1:0] {
    WAIT_PHASE = 2'd0,
    SETTLE     = 2'd1,
    HOLD       = 2'd2
  } state_e;

  localparam logic [1:0] COM_BAD  = 2'b00;
  localparam logic [1:0] COM_TENS = 2'b01;
  localparam logic [1:0] COM_ONES = 2'b10;
  localparam logic [1:0] COM_IDLE = 2'b11;

  // Bit order g f e d c b a
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_6_NT = 7'h7C;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_9_NT = 7'h67;

endpackage
`default_nettype wire

// File: rtl/seg7_to_bcd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_to_bcd : combinational 7-segment pattern to BCD digit decoder  (rev 1.0)
// ---------------------------------------------------------------------------
module seg7_to_bcd (
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       ok_o
);
  import seg_scan_decoder_pkg::*;

  always_comb begin
    digit_o = 4'd0;
    ok_o    = 1'b1;
    case (seg_i)
      SEG_0:              digit_o = 4'd0;
      SEG_1:              digit_o = 4'd1;
      SEG_2:              digit_o = 4'd2;
      SEG_3:              digit_o = 4'd3;
      SEG_4:              digit_o = 4'd4;
      SEG_5:              digit_o = 4'd5;
      SEG_6, SEG_6_NT:    digit_o = 4'd6;
      SEG_7:              digit_o = 4'd7;
      SEG_8:              digit_o = 4'd8;
      SEG_9, SEG_9_NT:    digit_o = 4'd9;
      default:            ok_o    = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_decoder : samples a 2-digit multiplexed 7-seg display into BCD  (rev 1.0)
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [7:0] SEG,
  input  logic [1:0] COM,
  output logic [3:0] Ten,
  output logic [3:0] One,
  output logic [7:0] Value,
  output logic       DP_H,
  output logic       DP_L,
  output logic       valid,
  output logic       update,
  output logic       err
);
  import seg_scan_decoder_pkg::*;

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  logic [7:0] seg_m_q, seg_s_q, seg_p_q;
  logic [1:0] com_m_q, com_s_q, com_p_q;

  // Two-flop synchroniser plus one history stage for change detection
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      seg_m_q <= '0;
      seg_s_q <= '0;
      seg_p_q <= '0;
      com_m_q <= COM_IDLE;
      com_s_q <= COM_IDLE;
      com_p_q <= COM_IDLE;
    end else begin
      seg_m_q <= SEG;
      seg_s_q <= seg_m_q;
      seg_p_q <= seg_s_q;
      com_m_q <= COM;
      com_s_q <= com_m_q;
      com_p_q <= com_s_q;
    end
  end

  logic [3:0] w_dec_digit;
  logic       w_dec_ok;
  logic       w_changed;

  seg7_to_bcd u_dec (
    .seg_i   (seg_s_q[6:0]),
    .digit_o (w_dec_digit),
    .ok_o    (w_dec_ok)
  );

  assign w_changed = (seg_s_q != seg_p_q) || (com_s_q != com_p_q);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, drop_q, bad_q, cap_q, cap_ones_q, cap_dp_q;
  logic [3:0]       cap_dig_q;

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q    <= WAIT_PHASE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      bad_q      <= 1'b0;
      cap_q      <= 1'b0;
      cap_ones_q <= 1'b0;
      cap_dp_q   <= 1'b0;
      cap_dig_q  <= '0;
    end else begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      bad_q  <= 1'b0;
      cap_q  <= 1'b0;
      if (com_s_q == COM_BAD) begin
        err_q   <= 1'b1;
        drop_q  <= 1'b1;
        state_q <= WAIT_PHASE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          WAIT_PHASE: begin
            if (com_s_q != COM_IDLE) begin
              state_q <= SETTLE;
              cnt_q   <= '0;
            end
          end
          SETTLE: begin
            if (com_s_q == COM_IDLE) begin
              state_q <= WAIT_PHASE;
            end else if (w_changed) begin
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= HOLD;
              if (w_dec_ok) begin
                cap_q      <= 1'b1;
                cap_ones_q <= (com_s_q == COM_ONES);
                cap_dig_q  <= w_dec_digit;
                cap_dp_q   <= seg_s_q[7];
              end else begin
                err_q  <= 1'b1;
                drop_q <= 1'b1;
                bad_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          HOLD: begin
            if (com_s_q != com_p_q) state_q <= WAIT_PHASE;
          end
          default: state_q <= WAIT_PHASE;
        endcase
      end
    end
  end

  logic            tens_seen_q, ones_seen_q, tens_dp_q, ones_dp_q;
  logic [3:0]      tens_dig_q, ones_dig_q, ten_q, one_q;
  logic [7:0]      value_q, w_value;
  logic            dph_q, dpl_q, valid_q, update_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            w_commit, w_diff;

  // tens*10 as tens*8 + tens*2, all in 8 bits
  assign w_value  = {1'b0, tens_dig_q, 3'b000} + {3'b000, tens_dig_q, 1'b0} + {4'b0000, ones_dig_q};
  assign w_commit = tens_seen_q && ones_seen_q;
  assign w_diff   = (w_value != value_q) || (tens_dp_q != dph_q) || (ones_dp_q != dpl_q);

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      tens_seen_q <= 1'b0;
      ones_seen_q <= 1'b0;
      tens_dig_q  <= '0;
      ones_dig_q  <= '0;
      tens_dp_q   <= 1'b0;
      ones_dp_q   <= 1'b0;
      ten_q       <= '0;
      one_q       <= '0;
      value_q     <= '0;
      dph_q       <= 1'b0;
      dpl_q       <= 1'b0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      update_q <= 1'b0;
      if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + TO_W'(1);
      if (w_commit) begin
        ten_q       <= tens_dig_q;
        one_q       <= ones_dig_q;
        value_q     <= w_value;
        dph_q       <= tens_dp_q;
        dpl_q       <= ones_dp_q;
        valid_q     <= 1'b1;
        update_q    <= !valid_q || w_diff;
        tens_seen_q <= 1'b0;
        ones_seen_q <= 1'b0;
        to_cnt_q    <= '0;
      end else if (to_cnt_q == TO_MAX) begin
        valid_q <= 1'b0;
      end
      if (drop_q) begin
        tens_seen_q <= 1'b0;
        ones_seen_q <= 1'b0;
      end else if (cap_q) begin
        if (cap_ones_q) begin
          ones_dig_q  <= cap_dig_q;
          ones_dp_q   <= cap_dp_q;
          ones_seen_q <= 1'b1;
        end else begin
          tens_dig_q  <= cap_dig_q;
          tens_dp_q   <= cap_dp_q;
          tens_seen_q <= 1'b1;
        end
      end
      if (bad_q) valid_q <= 1'b0;
    end
  end

  assign Ten    = ten_q;
  assign One    = one_q;
  assign Value  = value_q;
  assign DP_H   = dph_q;
  assign DP_L   = dpl_q;
  assign valid  = valid_q;
  assign update = update_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder : table-driven frames with an update scoreboard  (rev 1.0)
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

  logic       Sys_CLK = 1'b0;
  logic       Sys_RST = 1'b0;
  logic [7:0] SEG = 8'h00;
  logic [1:0] COM = 2'b11;
  logic [3:0] Ten, One;
  logic [7:0] Value;
  logic       DP_H, DP_L, valid, update, err;

  seg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(256)) dut (
    .Sys_CLK (Sys_CLK),
    .Sys_RST (Sys_RST),
    .SEG     (SEG),
    .COM     (COM),
    .Ten     (Ten),
    .One     (One),
    .Value   (Value),
    .DP_H    (DP_H),
    .DP_L    (DP_L),
    .valid   (valid),
    .update  (update),
    .err     (err)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  localparam logic [7:0] P0 = 8'h3F, P1 = 8'h06, P2 = 8'h5B, P3 = 8'h4F, P4 = 8'h66;
  localparam logic [7:0] P5 = 8'h6D, P6 = 8'h7D, P6N = 8'h7C, P7 = 8'h07, P8 = 8'h7F;
  localparam logic [7:0] P9 = 8'h6F, P9N = 8'h67, DP = 8'h80;

  typedef struct packed {
    logic [7:0] value;
    logic       dph;
    logic       dpl;
  } exp_t;

  typedef struct {
    logic [7:0] st;
    logic [7:0] so;
    logic       bad;
    int         ten;
    int         one;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t m_last = '0;
  logic m_valid = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   err_seen = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] s, input int n);
    @(negedge Sys_CLK);
    COM = c;
    SEG = s;
    repeat (n - 1) @(negedge Sys_CLK);
  endtask

  task automatic scan_frame(input logic [7:0] st, input logic [7:0] so);
    drive(2'b01, st, 40);
    drive(2'b11, 8'h00, 2);
    drive(2'b10, so, 40);
    drive(2'b11, 8'h00, 6);
  endtask

  task automatic expect_frame(input int ten, input int one, input logic dph, input logic dpl);
    exp_t e;
    e.value = 8'(ten * 10 + one);
    e.dph   = dph;
    e.dpl   = dpl;
    if (!m_valid || e != m_last) sb_q.push_back(e);
    m_last  = e;
    m_valid = 1'b1;
  endtask

  // Scoreboard side: every update pulse must match the oldest expected commit
  always @(negedge Sys_CLK) begin
    if (Sys_RST) begin
      if (err) err_seen++;
      if (update) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL update_unexpected: got Value=%0d DP=%b%b, want no pulse", Value, DP_H, DP_L);
        end else begin
          mon_e = sb_q.pop_front();
          if ({Value, DP_H, DP_L} != mon_e) begin
            n_fail++;
            $display("FAIL update_contents: got Value=%0d DP=%b%b, want Value=%0d DP=%b%b",
                     Value, DP_H, DP_L, mon_e.value, mon_e.dph, mon_e.dpl);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int e0;
    vt[0]  = '{P4,      P2,      1'b0, 4, 2};
    vt[1]  = '{P4,      P2,      1'b0, 4, 2};
    vt[2]  = '{P4,      P2,      1'b0, 4, 2};
    vt[3]  = '{P4,      P2,      1'b0, 4, 2};
    vt[4]  = '{P4,      P1,      1'b0, 4, 1};
    vt[5]  = '{P9 | DP, P9N,     1'b0, 9, 9};
    vt[6]  = '{P8,      8'h01,   1'b1, 9, 9};
    vt[7]  = '{P9 | DP, P9N,     1'b0, 9, 9};
    vt[8]  = '{P6N,     P7 | DP, 1'b0, 6, 7};
    vt[9]  = '{P0,      P0,      1'b0, 0, 0};
    vt[10] = '{P3,      P6,      1'b0, 3, 6};
    vt[11] = '{P8,      P5,      1'b0, 8, 5};

    repeat (3) @(negedge Sys_CLK);
    check("reset_outputs", {Ten, One, Value, DP_H, DP_L, valid, update, err}, 0);
    Sys_RST = 1'b1;

    for (int i = 0; i < NV; i++) begin
      e0 = err_seen;
      if (!vt[i].bad) expect_frame(vt[i].ten, vt[i].one, vt[i].st[7], vt[i].so[7]);
      else            m_valid = 1'b0;
      scan_frame(vt[i].st, vt[i].so);
      check($sformatf("v%0d_Ten", i),   Ten,   vt[i].ten);
      check($sformatf("v%0d_One", i),   One,   vt[i].one);
      check($sformatf("v%0d_Value", i), Value, vt[i].ten * 10 + vt[i].one);
      check($sformatf("v%0d_DP_H", i),  DP_H,  m_last.dph);
      check($sformatf("v%0d_DP_L", i),  DP_L,  m_last.dpl);
      check($sformatf("v%0d_valid", i), valid, m_valid);
      check($sformatf("v%0d_err", i),   err_seen - e0, vt[i].bad ? 1 : 0);
      check($sformatf("v%0d_sb", i),    sb_q.size(), 0);
    end

    // Glitching SEG every 10 cycles never lets a 16-cycle window settle
    e0 = err_seen;
    for (int k = 0; k < 4; k++) drive(2'b01, (k % 2 == 1) ? P5 : P4, 10);
    drive(2'b01, P4, 5);
    drive(2'b11, 8'h00, 2);
    for (int k = 0; k < 4; k++) drive(2'b10, (k % 2 == 1) ? P3 : P2, 10);
    drive(2'b10, P2, 5);
    drive(2'b11, 8'h00, 6);
    check("glitch_Value", Value, 85);
    check("glitch_valid", valid, 1);
    check("glitch_err", err_seen - e0, 0);
    scan_frame(P8, P5);
    check("refresh_Value", Value, 85);
    check("refresh_sb", sb_q.size(), 0);

    // One illegal COM cycle between the digits kills the partial frame
    e0 = err_seen;
    drive(2'b01, P4, 40);
    drive(2'b00, P4, 1);
    drive(2'b10, P1, 40);
    drive(2'b11, 8'h00, 6);
    check("com00_err", err_seen - e0, 1);
    check("com00_Value", Value, 85);
    check("com00_valid", valid, 1);
    expect_frame(7, 1, 1'b0, 1'b0);
    scan_frame(P7, P1);
    check("after00_Ten", Ten, 7);
    check("after00_Value", Value, 71);
    check("after00_sb", sb_q.size(), 0);

    // Scanning stops: valid survives short gaps, drops after the timeout
    drive(2'b11, 8'h00, 100);
    check("idle_short_valid", valid, 1);
    drive(2'b11, 8'h00, 200);
    check("timeout_valid", valid, 0);
    check("timeout_Value", Value, 71);
    check("timeout_Ten", Ten, 7);
    m_valid = 1'b0;

    // Reset in the middle of a settle window
    drive(2'b01, P3, 8);
    @(negedge Sys_CLK);
    Sys_RST = 1'b0;
    #1;
    check("midreset_outputs", {Ten, One, Value, DP_H, DP_L, valid, update, err}, 0);
    repeat (3) @(negedge Sys_CLK);
    Sys_RST = 1'b1;
    m_last = '0;
    drive(2'b10, P2, 40);
    drive(2'b11, 8'h00, 6);
    check("postreset_valid", valid, 0);
    check("postreset_Value", Value, 0);
    expect_frame(4, 2, 1'b0, 1'b0);
    scan_frame(P4, P2);
    check("postreset_frame_Value", Value, 42);
    check("postreset_frame_valid", valid, 1);
    check("final_sb", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
